// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, frame limits and the TX framer state encoding.
package uart_pkg;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_ODD   = 3'd1;
  localparam logic [2:0] PAR_EVEN  = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  localparam int unsigned MIN_DATA_LEN = 5;
  localparam int unsigned MAX_DATA_LEN = 9;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } tx_state_e;

endpackage

// File: rtl/uart_tx_framer_if.sv
// Producer/line bundle for the UART TX framer; the framer uses the slave side.
interface uart_tx_framer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_W      = 4
);
  logic                  baud_tick;
  logic                  data_valid;
  logic                  data_ready;
  logic [DATA_WIDTH-1:0] parallel_data;
  logic [LEN_W-1:0]      cfg_data_len;
  logic [2:0]            cfg_parity_mode;
  logic                  cfg_stop2;
  logic                  tx_serial;
  logic                  parity_bit;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output baud_tick, data_valid, parallel_data, cfg_data_len, cfg_parity_mode, cfg_stop2,
    input  data_ready, tx_serial, parity_bit, busy, frame_done
  );

  modport slave (
    input  baud_tick, data_valid, parallel_data, cfg_data_len, cfg_parity_mode, cfg_stop2,
    output data_ready, tx_serial, parity_bit, busy, frame_done
  );
endinterface

// File: rtl/uart_parity_gen.sv
// Combinational parity over the low len_i bits of data_i, for all parity modes.
module uart_parity_gen
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_W      = 4
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [LEN_W-1:0]      len_i,
  input  logic [2:0]            mode_i,
  output logic                  parity_o,
  output logic                  enable_o
);

  logic [DATA_WIDTH-1:0] masked;

  always_comb begin
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      masked[i] = data_i[i] & (i < int'(len_i));
    end
  end

  // Modes 5..7 fall through to "no parity".
  always_comb begin
    parity_o = 1'b0;
    enable_o = 1'b0;
    case (mode_i)
      PAR_ODD:   begin parity_o = ~^masked; enable_o = 1'b1; end
      PAR_EVEN:  begin parity_o = ^masked;  enable_o = 1'b1; end
      PAR_MARK:  begin parity_o = 1'b1;     enable_o = 1'b1; end
      PAR_SPACE: begin parity_o = 1'b0;     enable_o = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: accepts a word, then emits start, data (LSB first), parity and stop bits
// paced by baud_tick.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_W      = 4
) (
  input logic           UCLK,
  input logic           reset,
  uart_tx_framer_if.slave bus
);

  localparam int unsigned MaxLenInt = (DATA_WIDTH < MAX_DATA_LEN) ? DATA_WIDTH : MAX_DATA_LEN;
  localparam logic [LEN_W-1:0] MinLen = LEN_W'(MIN_DATA_LEN);
  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MaxLenInt);

  tx_state_e             state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      cnt_q;
  logic                  par_en_q;
  logic                  stop2_q;
  logic                  parity_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  done_q;

  logic [LEN_W-1:0]      len_clamped;
  logic                  par_calc;
  logic                  par_en_calc;

  always_comb begin
    len_clamped = bus.cfg_data_len;
    if (bus.cfg_data_len < MinLen) begin
      len_clamped = MinLen;
    end else if (bus.cfg_data_len > MaxLen) begin
      len_clamped = MaxLen;
    end
  end

  uart_parity_gen #(
    .DATA_WIDTH(DATA_WIDTH),
    .LEN_W     (LEN_W)
  ) u_parity_gen (
    .data_i  (bus.parallel_data),
    .len_i   (len_clamped),
    .mode_i  (bus.cfg_parity_mode),
    .parity_o(par_calc),
    .enable_o(par_en_calc)
  );

  always_ff @(posedge UCLK or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      len_q    <= MinLen;
      cnt_q    <= '0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.data_valid) begin
            shift_q  <= bus.parallel_data;
            len_q    <= len_clamped;
            par_en_q <= par_en_calc;
            stop2_q  <= bus.cfg_stop2;
            parity_q <= par_calc;
            busy_q   <= 1'b1;
            state_q  <= StSync;
          end
        end
        StSync: begin
          if (bus.baud_tick) begin
            tx_q    <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (bus.baud_tick) begin
            cnt_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= StData;
          end
        end
        StData: begin
          if (bus.baud_tick) begin
            shift_q <= {1'b0, shift_q[DATA_WIDTH-1:1]};
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == len_q - 1'b1) begin
              tx_q    <= par_en_q ? parity_q : 1'b1;
              state_q <= par_en_q ? StParity : StStop1;
            end else begin
              tx_q <= shift_q[1];
            end
          end
        end
        StParity: begin
          if (bus.baud_tick) begin
            tx_q    <= 1'b1;
            state_q <= StStop1;
          end
        end
        StStop1: begin
          if (bus.baud_tick) begin
            if (stop2_q) begin
              state_q <= StStop2;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        StStop2: begin
          if (bus.baud_tick) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.data_ready = (state_q == StIdle);
  assign bus.tx_serial  = tx_q;
  assign bus.parity_bit = parity_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule
